// File: rtl/pulse_out_pkg.sv
// Shared definitions for the pulse_out output stretcher: one-hot state encoding
// and the phase-counter width helper.
package pulse_out_pkg;

  localparam logic [2:0] IDLE_ENC = 3'b001;
  localparam logic [2:0] ON_ENC   = 3'b010;
  localparam logic [2:0] OFF_ENC  = 3'b100;

  // One-hot so that PIN and BUSY decode from the state register without glitches.
  typedef enum logic [2:0] {
    ST_IDLE = IDLE_ENC,
    ST_ON   = ON_ENC,
    ST_OFF  = OFF_ENC
  } state_e;

  function automatic int max_width(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/pulse_out_sat_updown.sv
// Saturating up/down counter; simultaneous inc and dec cancel, and the value
// never wraps in either direction.
module sat_updown #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] value_o,
  output logic         at_max_o,
  output logic         zero_o
);

  logic [W-1:0] value_q, value_d;

  assign value_o  = value_q;
  assign at_max_o = &value_q;
  assign zero_o   = (value_q == {W{1'b0}});

  // Next value with clamping at both ends.
  always_comb begin
    value_d = value_q;
    if (inc_i && !dec_i && !at_max_o) begin
      value_d = value_q + W'(1);
    end else if (dec_i && !inc_i && !zero_o) begin
      value_d = value_q - W'(1);
    end else begin
      value_d = value_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= {W{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/pulse_out.sv
// Turns single-cycle event strobes into pin pulses with guaranteed minimum high
// and low times; events arriving mid-pulse are queued and replayed back to back.
module pulse_out
  import pulse_out_pkg::*;
#(
  parameter int ON_BITS   = 16,
  parameter int OFF_BITS  = 16,
  parameter int PEND_BITS = 4,
  parameter int INVERT    = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EV,
  output logic                 PIN,
  output logic                 BUSY,
  output logic [PEND_BITS-1:0] PEND,
  output logic                 DROP
);

  localparam int CNT_W = max_width(ON_BITS, OFF_BITS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic             on_end_s, off_end_s;
  logic             inc_s, deq_s;
  logic             pend_max_s, pend_zero_s;

  assign on_end_s  = &cnt_q[ON_BITS-1:0];
  assign off_end_s = &cnt_q[OFF_BITS-1:0];

  // Phase sequencing and pending-queue control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    inc_s   = 1'b0;
    deq_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (EV) begin
          state_d = ST_ON;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ON: begin
        inc_s = EV;
        if (on_end_s) begin
          state_d = ST_OFF;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_ON;
        end
      end
      ST_OFF: begin
        if (off_end_s) begin
          cnt_d = {CNT_W{1'b0}};
          if (!pend_zero_s) begin
            // Replay a queued event; a concurrent EV takes its slot in the queue.
            state_d = ST_ON;
            deq_s   = 1'b1;
            inc_s   = EV;
          end else if (EV) begin
            state_d = ST_ON;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_OFF;
          inc_s   = EV;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    drop_d = inc_s && pend_max_s && !deq_s;
  end

  // State, phase counter and DROP registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  sat_updown #(
    .W (PEND_BITS)
  ) u_pend (
    .clk_i    (CLK),
    .rst_i    (RST),
    .inc_i    (inc_s),
    .dec_i    (deq_s),
    .value_o  (PEND),
    .at_max_o (pend_max_s),
    .zero_o   (pend_zero_s)
  );

  assign PIN  = (state_q == ST_ON) ^ (INVERT != 0);
  assign BUSY = (state_q != ST_IDLE);
  assign DROP = drop_q;

endmodule

// File: tb/tb_pulse_out.sv
// Self-checking bench for pulse_out: a pulse-schedule model pushes the expected
// outputs of every cycle to a queue, each test pops and compares them.
module tb_pulse_out;

  logic       clk, rst, ev;
  logic       pin, busy, drop;
  logic [1:0] pend;
  logic       pin_n, busy_n, drop_n;
  logic [1:0] pend_n;

  typedef struct {
    int s;
    bit q;
  } pulse_t;

  pulse_t     sched[$];
  logic [4:0] exp_q[$];
  int         t;
  int         busy_until;
  int         n_cmp;
  int         n_bad;

  pulse_out #(.ON_BITS(2), .OFF_BITS(3), .PEND_BITS(2), .INVERT(0)) dut (
    .CLK(clk), .RST(rst), .EV(ev), .PIN(pin), .BUSY(busy), .PEND(pend), .DROP(drop)
  );

  pulse_out #(.ON_BITS(2), .OFF_BITS(3), .PEND_BITS(2), .INVERT(1)) dut_inv (
    .CLK(clk), .RST(rst), .EV(ev), .PIN(pin_n), .BUSY(busy_n), .PEND(pend_n), .DROP(drop_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hold reset (with EV high, which must be ignored) and restart the model at cycle 0.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ev  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ev  = 1'b0;
    t = 0;
    busy_until = 0;
    sched.delete();
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus, schedule the pulses it implies and push the
  // expected output vector {pin, busy, pend, drop} for the following cycle.
  task automatic step(input logic ev_v, input logic rst_v);
    int   pend_now;
    bit   deq;
    bit   drp;
    int   u;
    logic e_pin, e_busy;
    int   e_pend;
    ev  = ev_v;
    rst = rst_v;
    drp = 1'b0;
    u   = t + 1;
    if (rst_v) begin
      sched.delete();
      busy_until = 0;
    end else if (ev_v) begin
      pend_now = 0;
      deq = 1'b0;
      foreach (sched[i]) begin
        if (sched[i].q && sched[i].s > t) pend_now++;
        if (sched[i].q && sched[i].s == u) deq = 1'b1;
      end
      if (u >= busy_until) begin
        sched.push_back('{s: u, q: 1'b0});
        busy_until = u + 12;
      end else if (pend_now == 3 && !deq) begin
        drp = 1'b1;
      end else begin
        sched.push_back('{s: busy_until, q: 1'b1});
        busy_until = busy_until + 12;
      end
    end
    e_pin = 1'b0;
    e_busy = 1'b0;
    e_pend = 0;
    foreach (sched[i]) begin
      if (sched[i].s <= u && u < sched[i].s + 4) e_pin = 1'b1;
      if (sched[i].s <= u && u < sched[i].s + 12) e_busy = 1'b1;
      if (sched[i].q && sched[i].s > u) e_pend++;
    end
    exp_q.push_back({e_pin, e_busy, e_pend[1:0], drp});
    @(negedge clk);
    t = t + 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({pin, busy, pend, drop} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset got=%b want=%b", {pin, busy, pend, drop}, 5'b00000);
    end
    n_cmp++;
    if ({pin_n, busy_n, pend_n, drop_n} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_inv got=%b want=%b", {pin_n, busy_n, pend_n, drop_n}, 5'b10000);
    end
  endtask

  task automatic test_single();
    logic [127:0] m;
    logic [4:0]   e;
    m = '0;
    m[10] = 1'b1;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      step(m[c], 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({pin, busy, pend, drop} !== e) begin
        n_bad++;
        $display("FAIL single cyc=%0d got=%b want=%b", t, {pin, busy, pend, drop}, e);
      end
      if (t == 23) begin
        n_cmp++;
        if (busy !== 1'b0 || pin !== 1'b0) begin
          n_bad++;
          $display("FAIL single_idle cyc=23 got busy=%b pin=%b want 0 0", busy, pin);
        end
      end
    end
  endtask

  task automatic test_three();
    logic [127:0] m;
    logic [4:0]   e;
    logic         prev;
    int           rises[$];
    int           want[3] = '{11, 23, 35};
    m = '0;
    m[10] = 1'b1;
    m[12] = 1'b1;
    m[13] = 1'b1;
    do_reset();
    prev = pin;
    for (int c = 0; c < 50; c++) begin
      step(m[c], 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({pin, busy, pend, drop} !== e) begin
        n_bad++;
        $display("FAIL three cyc=%0d got=%b want=%b", t, {pin, busy, pend, drop}, e);
      end
      if (pin && !prev) rises.push_back(t);
      prev = pin;
      if (t == 46 || t == 47) begin
        n_cmp++;
        if (busy !== (t == 46)) begin
          n_bad++;
          $display("FAIL three_busy cyc=%0d got=%b want=%b", t, busy, (t == 46));
        end
      end
    end
    n_cmp++;
    if (rises.size() != 3) begin
      n_bad++;
      $display("FAIL three_rises got=%0d want=3", rises.size());
    end else begin
      foreach (want[i]) begin
        n_cmp++;
        if (rises[i] != want[i]) begin
          n_bad++;
          $display("FAIL three_rise%0d got=%0d want=%0d", i, rises[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_saturate();
    logic [127:0] m;
    logic [4:0]   e;
    logic         prev;
    int           rises;
    m = '0;
    m[10] = 1'b1;
    for (int k = 12; k <= 16; k++) m[k] = 1'b1;
    do_reset();
    prev = pin;
    rises = 0;
    for (int c = 0; c < 65; c++) begin
      step(m[c], 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({pin, busy, pend, drop} !== e) begin
        n_bad++;
        $display("FAIL saturate cyc=%0d got=%b want=%b", t, {pin, busy, pend, drop}, e);
      end
      if (pin && !prev) rises++;
      prev = pin;
      if (t >= 15 && t <= 18) begin
        n_cmp++;
        if (drop !== (t == 16 || t == 17) || pend !== 2'd3) begin
          n_bad++;
          $display("FAIL saturate_drop cyc=%0d got drop=%b pend=%0d", t, drop, pend);
        end
      end
    end
    n_cmp++;
    if (rises != 4) begin
      n_bad++;
      $display("FAIL saturate_pulses got=%0d want=4", rises);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] m;
    logic [4:0]   e;
    logic         prev;
    int           rises;
    m = '0;
    m[10] = 1'b1;
    m[12] = 1'b1;
    m[13] = 1'b1;
    m[14] = 1'b1;
    m[22] = 1'b1;
    do_reset();
    prev = pin;
    rises = 0;
    for (int c = 0; c < 75; c++) begin
      step(m[c], 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({pin, busy, pend, drop} !== e) begin
        n_bad++;
        $display("FAIL b2b cyc=%0d got=%b want=%b", t, {pin, busy, pend, drop}, e);
      end
      if (pin && !prev) rises++;
      prev = pin;
      if (t == 23) begin
        n_cmp++;
        if (pend !== 2'd3 || drop !== 1'b0 || pin !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_lastoff cyc=23 got pend=%0d drop=%b pin=%b want 3 0 1", pend, drop, pin);
        end
      end
    end
    n_cmp++;
    if (rises != 5) begin
      n_bad++;
      $display("FAIL b2b_pulses got=%0d want=5", rises);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] m;
    logic [4:0]   e;
    m = '0;
    m[10] = 1'b1;
    m[11] = 1'b1;
    m[12] = 1'b1;
    m[13] = 1'b1;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      step(m[c], (c == 13));
      e = exp_q.pop_front();
      n_cmp++;
      if ({pin, busy, pend, drop} !== e) begin
        n_bad++;
        $display("FAIL reset_mid cyc=%0d got=%b want=%b", t, {pin, busy, pend, drop}, e);
      end
      if (t == 13 || t == 14) begin
        n_cmp++;
        if ({pin, busy, pend} !== ((t == 13) ? 4'b1110 : 4'b0000)) begin
          n_bad++;
          $display("FAIL reset_mid_pt cyc=%0d got=%b", t, {pin, busy, pend});
        end
      end
    end
  endtask

  task automatic test_invert();
    logic [127:0] m;
    logic [4:0]   e;
    int           low_cnt;
    m = '0;
    m[10] = 1'b1;
    do_reset();
    low_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      step(m[c], 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({pin_n, busy_n, pend_n, drop_n} !== {~e[4], e[3:0]}) begin
        n_bad++;
        $display("FAIL invert cyc=%0d got=%b want=%b", t, {pin_n, busy_n, pend_n, drop_n}, {~e[4], e[3:0]});
      end
      if (pin_n === 1'b0) low_cnt++;
    end
    n_cmp++;
    if (low_cnt != 4) begin
      n_bad++;
      $display("FAIL invert_low got=%0d want=4", low_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    ev = 1'b0;
    t = 0;
    busy_until = 0;
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_three();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    test_invert();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_out.md
# pulse_out

Output-side counterpart to the push-button debouncer: turns single-cycle event strobes (for example debounced press/release pulses or counter ticks) into a clean, human-visible pin waveform with a guaranteed minimum high time and low time. Strobes arriving while a pulse is in progress are counted and replayed back to back, so no event is merged or lost until the pending counter saturates. The block drives LEDs, buzzers or off-board lines on the counter board, and sits between the event logic and the output pin.

## Interface
Parameters:
- ON_BITS, 16: high phase lasts exactly 2^ON_BITS cycles.
- OFF_BITS, 16: low (recovery) phase lasts exactly 2^OFF_BITS cycles.
- PEND_BITS, 4: width of the pending-event counter; max queued = 2^PEND_BITS − 1.
- INVERT, 0: 1 inverts the pin (active-low LED).

Ports:
- CLK  in  1  sole clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- EV  in  1  event strobe, one cycle per event; a level held N cycles counts as N events.
- PIN  out  1  output waveform: logical level XOR INVERT.
- BUSY  out  1  1 while state ≠ IDLE.
- PEND  out  PEND_BITS  events accepted but not yet started.
- DROP  out  1  one-cycle pulse when an EV is discarded because of saturation.

## Operation
- States: IDLE, ON, OFF. Phase counter width is max(ON_BITS, OFF_BITS), cleared on every phase entry.
- IDLE: logical level 0. When EV=1, go to ON next cycle. PEND is unchanged.
- ON: logical level 1. The counter increments each cycle. When the low ON_BITS bits are all ones, go to OFF and clear the counter.
- OFF: logical level 0. The counter increments. When the low OFF_BITS bits are all ones:
  - if PEND>0, or EV=1 that cycle, go to ON;
  - otherwise go to IDLE.
- Pending counter, ON and OFF states:
  - EV alone increments PEND.
  - A dequeue happens at the end of OFF when PEND>0 and decrements PEND.
  - EV plus a dequeue in the same cycle leaves PEND unchanged. This case is never a drop, even when PEND is saturated.
  - EV at the end of OFF with PEND=0 goes straight to ON without touching PEND.
  - EV with PEND all ones and no dequeue: PEND stays, DROP=1 for that cycle.
- PEND never wraps in either direction.
- Reset values: state IDLE, counter 0, PEND 0, DROP 0, BUSY 0, PIN = INVERT. EV in the same cycle as RST is ignored.
- Reset mid-pulse aborts the pulse immediately: PIN returns to its idle level on the next edge, and the queued events are discarded.

## Timing
- Latency: EV sampled at edge t while IDLE → PIN active from edge t+1.
- Each pulse: exactly 2^ON_BITS cycles active, then exactly 2^OFF_BITS cycles inactive.
- Back-to-back queued pulses: period exactly 2^ON_BITS + 2^OFF_BITS cycles, with no extra IDLE cycle between them.
- After the last pulse, BUSY falls at the same edge where PIN has been inactive for 2^OFF_BITS cycles.
- All outputs are registered except BUSY and PIN, which are decoded from the state register. They are glitch-free because the state is one-hot or gray-encoded.
- DROP is registered and asserted in cycle t+1 for an EV sampled at t.

## Structure
- Shared package `pulse_out_pkg`: state encoding localparams (IDLE, ON, OFF, one-hot) and the max(ON_BITS, OFF_BITS) width helper function.
- Sub-module `sat_updown`: parameterised saturating up/down counter. Inputs inc and dec; outputs value, at_max and zero. inc+dec in the same cycle is a no-op. It is reused later for the other LED channels.
- The top contains the FSM, the phase counter, the DROP register and the output XOR.

## Test plan
All tests use ON_BITS=2 (4 cycles), OFF_BITS=3 (8 cycles), PEND_BITS=2 (max 3), INVERT=0.
- Single EV at cycle 10 → PIN=1 for cycles 11–14, PIN=0 for 15–22, BUSY=0 from 23, PEND stays 0.
- Three EVs at cycles 10, 12, 13 → PEND goes 0→1→2, then three pulses with rising edges at 11, 23, 35, and BUSY falls at 47.
- Five EVs at cycles 12–16 (during the first pulse) → PEND saturates at 3 after cycle 14. DROP pulses at cycles 16 and 17 (registered, for EVs at 15 and 16). Exactly four pulses total.
- EV exactly on the last OFF cycle with PEND=3 → no DROP, PEND remains 3, next pulse starts immediately.
- RST at cycle 13, mid-ON with PEND=2 → at cycle 14 PIN=0, PEND=0, BUSY=0, and no further pulses appear.
- INVERT=1, one EV → PIN idles at 1 and is driven 0 for 4 cycles. Repeat the first scenario with identical timing.
